// File: rtl/lemmings_walker_if.sv
// lemmings_walker_if: environment inputs and Moore outputs of the Lemming walker.
// master = environment (drives bumps/ground/dig), slave = walker FSM.
interface lemmings_walker_if;
    logic bump_left;
    logic bump_right;
    logic ground;
    logic dig;
    logic walk_left;
    logic walk_right;
    logic aaah;
    logic digging;
    logic splat;

    modport master (
        output bump_left, bump_right, ground, dig,
        input  walk_left, walk_right, aaah, digging, splat
    );

    modport slave (
        input  bump_left, bump_right, ground, dig,
        output walk_left, walk_right, aaah, digging, splat
    );
endinterface

// File: rtl/lemmings_walker.sv
// lemmings_walker: seven-state walk/fall/dig/splat controller.
// Falls longer than SPLAT_CYCLES cycles end in the terminal SPLAT state.
// Optional feature macro: LEMMINGS_DIG_LIMIT_EN -- when defined, a dig lasts
// at most DIG_MAX cycles before the lemming resumes walking.
module lemmings_walker #(
    parameter int unsigned SPLAT_CYCLES = 20,
    parameter int unsigned DIG_MAX      = 8
) (
    input logic               clk,
    input logic               areset,
    lemmings_walker_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(SPLAT_CYCLES + 2);
    localparam logic [CNT_W-1:0] SPLAT_LIM = CNT_W'(SPLAT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SPLAT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef LEMMINGS_DIG_LIMIT_EN
    localparam int unsigned DIG_W = $clog2(DIG_MAX + 1);
    localparam logic [DIG_W-1:0] DIG_LIM = DIG_W'(DIG_MAX);
    localparam logic [DIG_W-1:0] DIG_ONE = DIG_W'(1);
`endif

    // Elaboration-time range check of the configuration parameters
    if (SPLAT_CYCLES < 1) begin : g_bad_splat
        $error("lemmings_walker: SPLAT_CYCLES must be >= 1");
    end
    if (DIG_MAX < 1) begin : g_bad_dig
        $error("lemmings_walker: DIG_MAX must be >= 1");
    end

    typedef enum logic [2:0] {
        WALK_L = 3'd0,
        WALK_R = 3'd1,
        FALL_L = 3'd2,
        FALL_R = 3'd3,
        DIG_L  = 3'd4,
        DIG_R  = 3'd5,
        SPLAT  = 3'd6
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] fall_cnt;
    logic [CNT_W-1:0] fall_inc;
`ifdef LEMMINGS_DIG_LIMIT_EN
    logic [DIG_W-1:0] dig_cnt;
`endif

    // Saturating increment of the fall length counter
    always_comb begin
        fall_inc = (fall_cnt == CNT_MAX) ? CNT_MAX : fall_cnt + CNT_ONE;
    end

    // Next-state and counter update; counters default to clear every cycle
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state    <= WALK_L;
            fall_cnt <= '0;
`ifdef LEMMINGS_DIG_LIMIT_EN
            dig_cnt  <= '0;
`endif
        end else begin
            fall_cnt <= '0;
`ifdef LEMMINGS_DIG_LIMIT_EN
            dig_cnt  <= '0;
`endif
            case (state)
                WALK_L: begin
                    if (!bus.ground) begin
                        state    <= FALL_L;
                        fall_cnt <= CNT_ONE;
                    end else if (bus.dig) begin
                        state <= DIG_L;
`ifdef LEMMINGS_DIG_LIMIT_EN
                        dig_cnt <= DIG_ONE;
`endif
                    end else if (bus.bump_left) begin
                        state <= WALK_R;
                    end
                end
                WALK_R: begin
                    if (!bus.ground) begin
                        state    <= FALL_R;
                        fall_cnt <= CNT_ONE;
                    end else if (bus.dig) begin
                        state <= DIG_R;
`ifdef LEMMINGS_DIG_LIMIT_EN
                        dig_cnt <= DIG_ONE;
`endif
                    end else if (bus.bump_right) begin
                        state <= WALK_L;
                    end
                end
                FALL_L: begin
                    if (!bus.ground) begin
                        fall_cnt <= fall_inc;
                    end else if (fall_cnt > SPLAT_LIM) begin
                        state <= SPLAT;
                    end else begin
                        state <= WALK_L;
                    end
                end
                FALL_R: begin
                    if (!bus.ground) begin
                        fall_cnt <= fall_inc;
                    end else if (fall_cnt > SPLAT_LIM) begin
                        state <= SPLAT;
                    end else begin
                        state <= WALK_R;
                    end
                end
                DIG_L: begin
                    if (!bus.ground) begin
                        state    <= FALL_L;
                        fall_cnt <= CNT_ONE;
                    end else begin
`ifdef LEMMINGS_DIG_LIMIT_EN
                        if (dig_cnt == DIG_LIM) begin
                            state <= WALK_L;
                        end else begin
                            dig_cnt <= dig_cnt + DIG_ONE;
                        end
`else
                        state <= DIG_L;
`endif
                    end
                end
                DIG_R: begin
                    if (!bus.ground) begin
                        state    <= FALL_R;
                        fall_cnt <= CNT_ONE;
                    end else begin
`ifdef LEMMINGS_DIG_LIMIT_EN
                        if (dig_cnt == DIG_LIM) begin
                            state <= WALK_R;
                        end else begin
                            dig_cnt <= dig_cnt + DIG_ONE;
                        end
`else
                        state <= DIG_R;
`endif
                    end
                end
                SPLAT: begin
                    state <= SPLAT;
                end
                default: begin
                    state <= WALK_L;
                end
            endcase
        end
    end

    // Moore output decode straight from the state register; illegal codes give all-zero
    always_comb begin
        bus.walk_left  = 1'b0;
        bus.walk_right = 1'b0;
        bus.aaah       = 1'b0;
        bus.digging    = 1'b0;
        bus.splat      = 1'b0;
        case (state)
            WALK_L:         bus.walk_left  = 1'b1;
            WALK_R:         bus.walk_right = 1'b1;
            FALL_L, FALL_R: bus.aaah       = 1'b1;
            DIG_L, DIG_R:   bus.digging    = 1'b1;
            SPLAT:          bus.splat      = 1'b1;
            default:        ;
        endcase
    end

endmodule

// File: doc/lemmings_walker.md
# lemmings_walker

Parametrised Lemming walker FSM, the successor to the fixed six-state walk/fall/dig controller. It adds fall-duration tracking with a configurable splat threshold, a terminal SPLAT state, and an optional compile-time dig-length limit. It sits in the same behavioural-puzzle test suite and is driven directly by the environment inputs, one step per clock.

## Interface
- SPLAT_CYCLES, default 20: maximum survivable fall length in cycles; falling longer than this ends in SPLAT (legal range ≥1).
- DIG_MAX, default 8: maximum consecutive digging cycles; used only when LEMMINGS_DIG_LIMIT_EN is defined (legal range ≥1).
- clk  input  1  rising-edge clock.
- areset  input  1  reset, asynchronous, active-high; forces WALK_L.
- bump_left  input  1  obstacle on left.
- bump_right  input  1  obstacle on right.
- ground  input  1  ground present beneath lemming.
- dig  input  1  dig request.
- walk_left  output  1  high in WALK_L.
- walk_right  output  1  high in WALK_R.
- aaah  output  1  high in FALL_L/FALL_R.
- digging  output  1  high in DIG_L/DIG_R.
- splat  output  1  high in SPLAT.

## Operation
- The block has seven states: WALK_L, WALK_R, FALL_L, FALL_R, DIG_L, DIG_R, SPLAT. Outputs are Moore-decoded from state only and are one-hot or all-zero.
- WALK_x: the first matching condition wins.
  - !ground → FALL_x.
  - else dig → DIG_x.
  - else the facing bump → the opposite walk state.
  - else stay.
  - The non-facing bump is ignored. Both bumps asserted are treated as the facing bump.
- FALL_x:
  - !ground → stay.
  - ground with fall_cnt > SPLAT_CYCLES → SPLAT.
  - ground otherwise → WALK_x, keeping the original direction.
  - Bumps and dig are ignored while falling.
- DIG_x:
  - !ground → FALL_x.
  - else keep digging. The dig input is not required to stay high.
  - Bumps are ignored.
- SPLAT is terminal: all inputs are ignored until areset.
- fall_cnt register:
  - Width CNT_W = $clog2(SPLAT_CYCLES+2). Saturates at SPLAT_CYCLES+1.
  - Loaded with 1 on any transition into FALL_x.
  - Incremented (saturating) on FALL→FALL.
  - Cleared to 0 otherwise.
  - In a FALL cycle, fall_cnt equals the number of cycles aaah has been high, counting the current cycle.
- Unreachable state encodings → WALK_L on the next clock. In such an encoding all outputs are 0.

## Timing
- Reset value: walk_left=1; walk_right, aaah, digging, splat=0; fall_cnt=0; dig_cnt=0.
- areset asserted mid-fall, mid-dig or in SPLAT returns the block to WALK_L immediately, without waiting for a clock. Deasserting areset does not change state until the next clock.
- All transitions occur on the rising clk edge, with one cycle of latency from input to output.
- A fall with aaah high for exactly N cycles survives if N ≤ SPLAT_CYCLES. It splats if N ≥ SPLAT_CYCLES+1.
- Ground dropping in the same cycle as dig or bump: falling takes priority, and the direction is preserved.

## Configuration
- LEMMINGS_DIG_LIMIT_EN defined:
  - A dig_cnt register ($clog2(DIG_MAX+1) bits) is loaded with 1 on entry to DIG_x and increments in DIG_x.
  - In DIG_x with ground=1 and dig_cnt == DIG_MAX → WALK_x. digging stays high for exactly DIG_MAX cycles.
  - !ground still takes priority, giving FALL_x.
  - dig_cnt is cleared outside DIG_x.
- LEMMINGS_DIG_LIMIT_EN undefined: digging is unbounded, dig_cnt is not instantiated, and DIG_MAX is unused.

## Test plan
- Reset, then ground=1 with no other input for 5 clocks → walk_left=1 throughout. Pulse bump_left for 1 clock → walk_right=1 on the next cycle.
- SPLAT_CYCLES=20: from WALK_R, ground=0 for 20 cycles then ground=1 → aaah high for 20 cycles, then walk_right=1, splat=0.
- Same as the previous case but ground=0 for 21 cycles → splat=1 after landing. Then toggle ground, dig and bumps for 10 cycles → splat stays 1 and all other outputs stay 0. areset → walk_left=1.
- WALK_L with dig=1 → digging=1 next cycle. Drop dig → digging stays high. ground=0 → aaah=1. Ground returns after 3 cycles → walk_left=1.
- Mid-fall (aaah high for 10 cycles), assert areset asynchronously between edges → walk_left=1 before the next edge. A subsequent 15-cycle fall survives, confirming fall_cnt was cleared.
- With LEMMINGS_DIG_LIMIT_EN and DIG_MAX=8: dig from WALK_R with ground=1 → digging high for exactly 8 cycles, then walk_right=1. Without the macro → digging stays high for at least 50 cycles.
